crc8_frame_unit: RTL



---
 rtl/crc8_frame_unit.sv | 96 +++++++++
 1 files changed

// File: rtl/crc8_frame_unit.sv
// CRC-8 (MSB-first, no reflection, no final XOR) over last-delimited frames; result valid 1 cycle after last beat.
// Input stalls (in_ready=0) only while a result waits for out_ready; one full beat is folded per cycle.
module crc8_frame_unit #(
    parameter int         DATA_W = 8,
    parameter logic [7:0] POLY   = 8'h07,
    parameter logic [7:0] INIT   = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [7:0]        out_crc,
    output logic              out_ok,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCUM  = 2'd1;
    localparam logic [1:0] RESULT = 2'd2;

    logic [1:0]        state;
    logic [7:0]        crc_reg;
    logic [7:0]        crc_base;
    logic [7:0]        crc_next;
    logic [DATA_W-1:0] data_gated;
    logic              accept;

    // Unrolled per-bit LFSR step: the whole beat collapses into one XOR tree.
    function automatic logic [7:0] crc_update(input logic [7:0] crc_in,
                                              input logic [DATA_W-1:0] d);
        logic [7:0] c;
        logic       fb;
        c = crc_in;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
        end
        return c;
    endfunction

    assign in_ready = (state != RESULT);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;

    // Idle data is masked so an undriven bus never reaches the XOR tree.
    assign data_gated = in_valid ? in_data : '0;
    // A new frame always starts from INIT, whatever crc_reg holds.
    assign crc_base   = (state == ACCUM) ? crc_reg : INIT;

    always_comb begin
        crc_next = crc_update(crc_base, data_gated);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            crc_reg   <= INIT;
            out_crc   <= 8'h00;
            out_ok    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        if (in_last) begin
                            out_crc   <= crc_next;
                            out_ok    <= (crc_next == 8'h00);
                            out_valid <= 1'b1;
                            crc_reg   <= INIT;
                            state     <= RESULT;
                        end else begin
                            crc_reg <= crc_next;
                            state   <= ACCUM;
                        end
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    crc_reg   <= INIT;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
